// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between the multicycle controller and its datapath
//
// Inputs to the controller: decoded instruction fields (Op, I, L, Cond), ALU decoder
// results (FlagW, NoWrite), live ALU flags (ALUFlags) and the memory handshake (MemReady).
// Outputs from the controller: datapath write enables, mux selects, ALUOp and the
// architectural NZCV register (Flags).
interface multicycle_controller_if;
    logic [1:0] Op;
    logic       I;
    logic       L;
    logic [3:0] Cond;
    logic [1:0] FlagW;
    logic       NoWrite;
    logic [3:0] ALUFlags;
    logic       MemReady;

    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic [3:0] Flags;

    // Controller side
    modport master (
        input  Op, I, L, Cond, FlagW, NoWrite, ALUFlags, MemReady,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Flags
    );

    // Datapath side
    modport slave (
        output Op, I, L, Cond, FlagW, NoWrite, ALUFlags, MemReady,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Flags
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle control FSM with NZCV register and conditional execution
//
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   reset - synchronous, active-high; returns to FETCH, clears Flags and forces write enables low
//   bus   - multicycle_controller_if.master: instruction fields and handshake in,
//           datapath enables/selects, ALUOp and Flags out
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ALUWB,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        BRANCH
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] flags_q;     // {N, Z, C, V}
    logic       condex_q;    // condition outcome latched in DECODE
    logic       alu_op_q;

    logic       condex_now;
    logic       in_exec;

    // ARM condition evaluation against the architectural flags
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = !z;
            4'b0010: cond_eval = c;
            4'b0011: cond_eval = !c;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = !n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = !v;
            4'b1000: cond_eval = c && !z;
            4'b1001: cond_eval = !c || z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = !z && (n == v);
            4'b1101: cond_eval = z || (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign condex_now = cond_eval(bus.Cond, flags_q);
    assign in_exec    = (state_q == EXEC_R) || (state_q == EXEC_I);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
            alu_op_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Loading ALUOp from the next-state decode makes it a clean flop output
            // that is high for exactly the EXEC cycle.
            alu_op_q <= (state_d == EXEC_R) || (state_d == EXEC_I);
            if (state_q == DECODE) begin
                condex_q <= condex_now;
            end
            // EXEC always lasts one cycle, so this edge is its exit edge.
            if (in_exec && condex_q) begin
                if (bus.FlagW[1]) begin
                    flags_q[3:2] <= bus.ALUFlags[3:2];
                end
                if (bus.FlagW[0]) begin
                    flags_q[1:0] <= bus.ALUFlags[1:0];
                end
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                if (!condex_now || bus.Op == 2'b11) begin
                    state_d = FETCH;
                end else begin
                    case (bus.Op)
                        2'b00:   state_d = bus.I ? EXEC_I : EXEC_R;
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            EXEC_R,
            EXEC_I:   state_d = bus.NoWrite ? FETCH : ALUWB;
            ALUWB:    state_d = FETCH;
            MEMADR:   state_d = bus.L ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = bus.MemReady ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = bus.MemReady ? FETCH : MEMWRITE;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Per-state outputs; write enables are masked by reset as a final step
    logic pc_write, ir_write, reg_write, mem_write;

    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        case (state_q)
            FETCH: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                ir_write      = bus.MemReady;
                pc_write      = bus.MemReady;
            end
            DECODE: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            EXEC_I: begin
                bus.ALUSrcB   = 2'b01;
            end
            ALUWB: begin
                reg_write     = condex_q;
            end
            MEMADR: begin
                bus.ALUSrcB   = 2'b01;
            end
            MEMREAD: begin
                bus.AdrSrc    = 1'b1;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_write     = condex_q;
            end
            MEMWRITE: begin
                bus.AdrSrc    = 1'b1;
                mem_write     = condex_q;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                pc_write      = condex_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.PCWrite  = pc_write  && !reset;
    assign bus.IRWrite  = ir_write  && !reset;
    assign bus.RegWrite = reg_write && !reset;
    assign bus.MemWrite = mem_write && !reset;
    assign bus.ALUOp    = alu_op_q;
    assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic       adr;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [1:0] rs;
        logic       aluop;
        logic [3:0] flags;
    } exp_t;

    exp_t       expq[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] mflags;      // model of architectural NZCV
    int         ncyc;

    // Condition truth table from the ARM encoding
    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
        case (cond)
            4'h0: return f[2];
            4'h1: return !f[2];
            4'h2: return f[1];
            4'h3: return !f[1];
            4'h4: return f[3];
            4'h5: return !f[3];
            4'h6: return f[0];
            4'h7: return !f[0];
            4'h8: return f[1] && !f[2];
            4'h9: return !f[1] || f[2];
            4'hA: return f[3] == f[0];
            4'hB: return f[3] != f[0];
            4'hC: return !f[2] && (f[3] == f[0]);
            4'hD: return f[2] || (f[3] != f[0]);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t mk(input logic pcw, input logic irw, input logic rw,
                                input logic mw, input logic adr, input logic [1:0] asa,
                                input logic [1:0] asb, input logic [1:0] rs,
                                input logic aluop);
        exp_t e;
        e.pcw   = pcw;
        e.irw   = irw;
        e.rw    = rw;
        e.mw    = mw;
        e.adr   = adr;
        e.asa   = asa;
        e.asb   = asb;
        e.rs    = rs;
        e.aluop = aluop;
        e.flags = mflags;
        return e;
    endfunction

    // Single compare process: every cycle with a queued expectation is checked
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            exp_t a;
            e = expq.pop_front();
            a = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp, bus.Flags};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t actual pcw,irw,rw,mw,adr,asa,asb,rs,aluop,flags=%b required=%b",
                         $time, a, e);
            end
        end
    end

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock cycle: drive MemReady/reset, queue this cycle's expectation
    task automatic step(input exp_t e, input logic mr, input logic rst);
        bus.MemReady = mr;
        reset        = rst;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its expected cycle-by-cycle outputs
    task automatic run_instr(input logic [1:0] op, input logic i, input logic l,
                             input logic [3:0] cond, input logic [1:0] fw, input logic nw,
                             input logic [3:0] af, input int fetch_wait, input int mem_wait,
                             output int n);
        logic ct;
        bus.Op       = op;
        bus.I        = i;
        bus.L        = l;
        bus.Cond     = cond;
        bus.FlagW    = fw;
        bus.NoWrite  = nw;
        bus.ALUFlags = af;
        n  = 0;
        ct = cond_true(cond, mflags);
        repeat (fetch_wait) begin
            step(mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0), 1'b0, 1'b0);
            n++;
        end
        step(mk(1, 1, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0), 1'b1, 1'b0);
        n++;
        step(mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0), 1'b1, 1'b0);
        n++;
        if (ct && op != 2'b11) begin
            case (op)
                2'b00: begin
                    step(mk(0, 0, 0, 0, 0, 2'b00, i ? 2'b01 : 2'b00, 2'b00, 1), 1'b1, 1'b0);
                    n++;
                    if (fw[1]) mflags[3:2] = af[3:2];
                    if (fw[0]) mflags[1:0] = af[1:0];
                    if (!nw) begin
                        step(mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0), 1'b1, 1'b0);
                        n++;
                    end
                end
                2'b01: begin
                    step(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0), 1'b1, 1'b0);
                    n++;
                    if (l) begin
                        repeat (mem_wait) begin
                            step(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0), 1'b0, 1'b0);
                            n++;
                        end
                        step(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0), 1'b1, 1'b0);
                        step(mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 0), 1'b1, 1'b0);
                        n += 2;
                    end else begin
                        repeat (mem_wait) begin
                            step(mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0), 1'b0, 1'b0);
                            n++;
                        end
                        step(mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0), 1'b1, 1'b0);
                        n++;
                    end
                end
                default: begin
                    step(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0), 1'b1, 1'b0);
                    n++;
                end
            endcase
        end
    endtask

    logic [3:0] cc_list [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h4, 4'h8, 4'h5, 4'h9};
    int         cc_len  [8] = '{2, 3, 2, 3, 3, 2, 2, 3};

    initial begin
        reset        = 1'b1;
        bus.Op       = 2'b00;
        bus.I        = 1'b0;
        bus.L        = 1'b0;
        bus.Cond     = 4'hE;
        bus.FlagW    = 2'b00;
        bus.NoWrite  = 1'b0;
        bus.ALUFlags = 4'h0;
        bus.MemReady = 1'b1;
        mflags       = 4'h0;
        @(posedge clk);
        #1;
        // second reset cycle: FETCH selects, enables forced low
        step(mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0), 1'b1, 1'b1);

        // data-processing register op with writeback
        run_instr(2'b00, 0, 0, 4'hE, 2'b00, 0, 4'h0, 0, 0, ncyc);
        check_val("dp_reg_cycles", ncyc, 4);

        // compare-type op
        run_instr(2'b00, 0, 0, 4'hE, 2'b11, 1, 4'b0110, 0, 0, ncyc);
        check_val("cmp_cycles", ncyc, 3);
        check_val("cmp_flags", int'(bus.Flags), 4'b0110);

        // immediate op, FlagW=00 leaves flags
        run_instr(2'b00, 1, 0, 4'hE, 2'b00, 0, 4'b1111, 0, 0, ncyc);
        check_val("dp_imm_cycles", ncyc, 4);
        check_val("flagw00_flags", int'(bus.Flags), 4'b0110);

        // load with three wait cycles in MEMREAD
        run_instr(2'b01, 0, 1, 4'hE, 2'b00, 0, 4'h0, 0, 3, ncyc);
        check_val("load_wait_cycles", ncyc, 8);

        // set Flags=0100 then NE branch is skipped, EQ branch taken
        run_instr(2'b00, 0, 0, 4'hE, 2'b11, 1, 4'b0100, 0, 0, ncyc);
        check_val("flags_0100", int'(bus.Flags), 4'b0100);
        run_instr(2'b10, 0, 0, 4'h1, 2'b00, 0, 4'h0, 0, 0, ncyc);
        check_val("ne_skip_cycles", ncyc, 2);
        run_instr(2'b10, 0, 0, 4'h0, 2'b00, 0, 4'h0, 0, 0, ncyc);
        check_val("eq_branch_cycles", ncyc, 3);

        // illegal class and never-condition are both skipped
        run_instr(2'b11, 0, 0, 4'hE, 2'b00, 0, 4'h0, 0, 0, ncyc);
        check_val("illegal_cycles", ncyc, 2);
        run_instr(2'b00, 0, 0, 4'hF, 2'b11, 0, 4'hF, 0, 0, ncyc);
        check_val("never_cycles", ncyc, 2);
        check_val("never_flags", int'(bus.Flags), 4'b0100);

        // partial flag write: clear, then write only N,Z
        run_instr(2'b00, 0, 0, 4'hE, 2'b11, 1, 4'b0000, 0, 0, ncyc);
        run_instr(2'b00, 0, 0, 4'hE, 2'b10, 0, 4'b1011, 0, 0, ncyc);
        check_val("partial_cycles", ncyc, 4);
        check_val("partial_flags", int'(bus.Flags), 4'b1000);

        // condition codes against N=1,Z=0,C=0,V=0
        for (int k = 0; k < 8; k++) begin
            run_instr(2'b10, 0, 0, cc_list[k], 2'b00, 0, 4'h0, 0, 0, ncyc);
            check_val($sformatf("cond_%h_cycles", cc_list[k]), ncyc, cc_len[k]);
        end

        // store with MemReady high, and fetch stalled two cycles
        run_instr(2'b01, 0, 0, 4'hE, 2'b00, 0, 4'h0, 0, 0, ncyc);
        check_val("store_cycles", ncyc, 4);
        run_instr(2'b00, 1, 0, 4'hE, 2'b01, 0, 4'b0011, 2, 0, ncyc);
        check_val("fetch_wait_cycles", ncyc, 6);
        check_val("cv_only_flags", int'(bus.Flags), 4'b1011);

        // reset asserted while MEMWRITE waits
        bus.Op   = 2'b01;
        bus.L    = 1'b0;
        bus.Cond = 4'hE;
        step(mk(1, 1, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0), 1'b1, 1'b0);
        step(mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0), 1'b1, 1'b0);
        step(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0), 1'b1, 1'b0);
        step(mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0), 1'b0, 1'b0);
        step(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0), 1'b0, 1'b1);
        mflags = 4'h0;
        check_val("flags_after_reset", int'(bus.Flags), 0);
        step(mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0), 1'b0, 1'b0);

        // normal operation resumes
        run_instr(2'b00, 0, 0, 4'hE, 2'b00, 0, 4'h0, 0, 0, ncyc);
        check_val("post_reset_cycles", ncyc, 4);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
